// File: rtl/nv_nvdla_cdma_dc_rsp_tracker_if.sv
// Handshake bundle for the CDMA DC response tracker.
// The FIFO pop port, the DMA response port and the forwarded output
// port are grouped here. The slave modport is the tracker's view and
// the master modport is the surrounding datapath's view.
`timescale 1ns/1ps

interface nv_nvdla_cdma_dc_rsp_tracker_if #(
    parameter int DATA_W = 512,
    parameter int LEN_W  = 6
);
    // request-length FIFO read side (entry = beats-1)
    logic              fifo_rd_req;
    logic              fifo_rd_ready;
    logic [LEN_W-1:0]  fifo_rd_data;

    // DMA read response beats
    logic              dma_rsp_valid;
    logic              dma_rsp_ready;
    logic [DATA_W-1:0] dma_rsp_data;

    // forwarded beats toward the DC datapath
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output fifo_rd_req,
        output fifo_rd_data,
        input  fifo_rd_ready,
        output dma_rsp_valid,
        output dma_rsp_data,
        input  dma_rsp_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );

    modport slave (
        input  fifo_rd_req,
        input  fifo_rd_data,
        output fifo_rd_ready,
        input  dma_rsp_valid,
        input  dma_rsp_data,
        output dma_rsp_ready,
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );
endinterface

// File: rtl/nv_nvdla_cdma_dc_rsp_tracker.sv
// CDMA DC response tracker.
// Pops one length entry (beats-1) per outstanding DMA read, counts the
// returning response beats against it, and forwards each beat through a
// one-deep registered stage tagged with a last flag. Also reports a
// per-request completion pulse and a wrapping completion count.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   ST_IDLE   | no length entry held; FIFO pop allowed, DMA held off
//   ST_ACTIVE | entry_len loaded; counting response beats
`timescale 1ns/1ps

module nv_nvdla_cdma_dc_rsp_tracker #(
    parameter int DATA_W     = 512,
    parameter int LEN_W      = 6,
    parameter int DONE_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_,
    nv_nvdla_cdma_dc_rsp_tracker_if.slave trk,
    output logic                  req_done,
    output logic [DONE_CNT_W-1:0] done_cnt,
    input  logic                  done_cnt_clr,
    output logic                  idle
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [LEN_W-1:0]  entry_len;
    logic [LEN_W-1:0]  beat_cnt;

    logic              out_valid_q;
    logic              out_last_q;
    logic [DATA_W-1:0] out_data_q;

    logic              ostg_free;
    logic              dma_rdy;
    logic              beat_acc;
    logic              last_acc;
    logic              fifo_rdy;
    logic              pop;

    // State register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake decode and next state. A pop is allowed on the cycle the
    // final beat is accepted so consecutive requests run without a bubble.
    always_comb begin
        state_nxt = state;
        ostg_free = !out_valid_q || trk.out_ready;
        dma_rdy   = (state == ST_ACTIVE) && ostg_free;
        beat_acc  = trk.dma_rsp_valid && dma_rdy;
        last_acc  = beat_acc && (beat_cnt == entry_len);
        fifo_rdy  = (state == ST_IDLE) || last_acc;
        pop       = trk.fifo_rd_req && fifo_rdy;
        case (state)
            ST_IDLE: begin
                if (pop) begin
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (last_acc) begin
                    state_nxt = pop ? ST_ACTIVE : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Entry length and beat counter; a pop always restarts the count,
    // including the pop that coincides with the previous request's last beat.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            entry_len <= '0;
            beat_cnt  <= '0;
        end else if (pop) begin
            entry_len <= trk.fifo_rd_data;
            beat_cnt  <= '0;
        end else if (beat_acc) begin
            beat_cnt  <= beat_cnt + LEN_W'(1);
        end
    end

    // One-deep output stage; data and last hold while the beat waits or
    // after it drains, only valid drops.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (beat_acc) begin
            out_valid_q <= 1'b1;
            out_last_q  <= (beat_cnt == entry_len);
            out_data_q  <= trk.dma_rsp_data;
        end else if (out_valid_q && trk.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Completion pulse and wrapping count; clear wins over increment but
    // the pulse is still raised.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            req_done <= 1'b0;
            done_cnt <= '0;
        end else begin
            req_done <= last_acc;
            if (done_cnt_clr) begin
                done_cnt <= '0;
            end else if (last_acc) begin
                done_cnt <= done_cnt + DONE_CNT_W'(1);
            end
        end
    end

    // Port drive.
    always_comb begin
        trk.fifo_rd_ready = fifo_rdy;
        trk.dma_rsp_ready = dma_rdy;
        trk.out_valid     = out_valid_q;
        trk.out_last      = out_last_q;
        trk.out_data      = out_data_q;
        idle              = (state == ST_IDLE) && !out_valid_q;
    end

endmodule

// File: tb/tb_nv_nvdla_cdma_dc_rsp_tracker.sv
// Self-checking bench for the CDMA DC response tracker.
// Inputs are driven just after the rising edge; every cycle the DUT is
// sampled at the falling edge against a small reference model and a
// scoreboard of expected output beats.
`timescale 1ns/1ps

module tb_nv_nvdla_cdma_dc_rsp_tracker;

    localparam int DATA_W     = 512;
    localparam int LEN_W      = 6;
    localparam int DONE_CNT_W = 16;

    logic                  clk = 1'b0;
    logic                  reset_ = 1'b0;
    logic                  req_done;
    logic [DONE_CNT_W-1:0] done_cnt;
    logic                  done_cnt_clr = 1'b0;
    logic                  idle;

    always #5 clk = ~clk;

    nv_nvdla_cdma_dc_rsp_tracker_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) trk();

    nv_nvdla_cdma_dc_rsp_tracker #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .DONE_CNT_W(DONE_CNT_W)
    ) dut (
        .clk          (clk),
        .reset_       (reset_),
        .trk          (trk),
        .req_done     (req_done),
        .done_cnt     (done_cnt),
        .done_cnt_clr (done_cnt_clr),
        .idle         (idle)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    typedef struct {
        int len0;
        int len1;       // -1: single entry
        int stall_at;   // accepted beat after which out_ready drops (0: none)
        int stall_len;
        int exp_beats;
        int exp_lasts;
    } vec_t;

    int                errors = 0;
    int                checks = 0;

    int                entry_q[$];
    logic [DATA_W-1:0] dma_q[$];
    beat_t             sb[$];

    bit                    m_active = 0;
    int                    m_len = 0;
    int                    m_bcnt = 0;
    logic [DONE_CNT_W-1:0] m_cnt = '0;
    bit                    m_done_pend = 0;

    int stall_at = 0, stall_len = 0, stall_left = 0, beats_in = 0;
    int n_out = 0, n_out_last = 0;
    int cyc = 0, t_pop = 0, t_beat = 0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [DATA_W-1:0] d;
        for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic drive();
        trk.fifo_rd_req   = (entry_q.size() != 0);
        trk.fifo_rd_data  = (entry_q.size() != 0) ? LEN_W'(entry_q[0]) : '0;
        trk.dma_rsp_valid = (dma_q.size() != 0);
        trk.dma_rsp_data  = (dma_q.size() != 0) ? dma_q[0] : '0;
        trk.out_ready     = (stall_left == 0);
    endtask

    task automatic monitor();
        bit exp_drdy, beat, last, pop;
        beat_t e;
        chk("out_valid", trk.out_valid, sb.size() != 0);
        chk("idle", idle, !m_active && sb.size() == 0);
        chk("req_done", req_done, m_done_pend);
        chk("done_cnt", done_cnt, m_cnt);
        exp_drdy = m_active && (sb.size() == 0 || trk.out_ready);
        chk("dma_rsp_ready", trk.dma_rsp_ready, exp_drdy);
        beat = trk.dma_rsp_valid && exp_drdy;
        last = beat && (m_bcnt == m_len);
        chk("fifo_rd_ready", trk.fifo_rd_ready, !m_active || last);
        pop = trk.fifo_rd_req && (!m_active || last);

        if (sb.size() != 0 && trk.out_ready) begin
            e = sb.pop_front();
            chk("out_data", trk.out_data, e.data);
            chk("out_last", trk.out_last, e.last);
            n_out++;
            if (trk.out_last) n_out_last++;
        end

        if (stall_left > 0 && !trk.out_ready) stall_left--;

        m_done_pend = last;
        if (done_cnt_clr) m_cnt = '0;
        else if (last)    m_cnt = m_cnt + 1'b1;

        if (beat) begin
            e.data = dma_q.pop_front();
            e.last = last;
            sb.push_back(e);
            m_bcnt++;
            beats_in++;
            t_beat = cyc;
            if (beats_in == stall_at) stall_left = stall_len;
            if (last) m_active = 0;
        end
        if (pop) begin
            m_len    = entry_q.pop_front();
            m_bcnt   = 0;
            m_active = 1;
            t_pop    = cyc;
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_empty(input int bound);
        int n = 0;
        while ((entry_q.size() != 0 || dma_q.size() != 0 || m_active || sb.size() != 0) && n < bound) begin
            step();
            n++;
        end
        chk("drain_in_budget", n < bound, 1'b1);
        step();
        step();
    endtask

    task automatic clr_counts();
        n_out = 0; n_out_last = 0; beats_in = 0;
        stall_at = 0; stall_len = 0; stall_left = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        logic [DONE_CNT_W-1:0] cnt0;
        int n;

        vecs[0] = '{len0: 0, len1: -1, stall_at: 0, stall_len: 0, exp_beats: 1,  exp_lasts: 1};
        vecs[1] = '{len0: 3, len1: 1,  stall_at: 0, stall_len: 0, exp_beats: 6,  exp_lasts: 2};
        vecs[2] = '{len0: 2, len1: -1, stall_at: 1, stall_len: 5, exp_beats: 3,  exp_lasts: 1};
        vecs[3] = '{len0: 5, len1: 0,  stall_at: 2, stall_len: 3, exp_beats: 7,  exp_lasts: 2};
        vecs[4] = '{len0: 7, len1: 7,  stall_at: 8, stall_len: 2, exp_beats: 16, exp_lasts: 2};

        drive();
        #3;
        chk("rst_out_valid", trk.out_valid, 1'b0);
        chk("rst_out_last", trk.out_last, 1'b0);
        chk("rst_out_data", trk.out_data, '0);
        chk("rst_req_done", req_done, 1'b0);
        chk("rst_done_cnt", done_cnt, '0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_fifo_rd_ready", trk.fifo_rd_ready, 1'b1);
        chk("rst_dma_rsp_ready", trk.dma_rsp_ready, 1'b0);
        @(negedge clk);
        reset_ = 1'b1;
        @(posedge clk);
        #1;

        // single-beat request, latency from pop to first DMA accept
        clr_counts();
        entry_q.push_back(0);
        begin
            logic [DATA_W-1:0] a5;
            a5 = {(DATA_W/8){8'hA5}};
            dma_q.push_back(a5);
        end
        run_until_empty(50);
        chk("lat_pop_to_beat", t_beat - t_pop, 1);
        chk("seq1_beats", n_out, 1);
        chk("seq1_done_cnt", done_cnt, 1);
        chk("seq1_idle", idle, 1'b1);

        for (int v = 0; v < 5; v++) begin
            int tot;
            clr_counts();
            stall_at  = vecs[v].stall_at;
            stall_len = vecs[v].stall_len;
            cnt0 = m_cnt;
            entry_q.push_back(vecs[v].len0);
            tot = vecs[v].len0 + 1;
            if (vecs[v].len1 >= 0) begin
                entry_q.push_back(vecs[v].len1);
                tot += vecs[v].len1 + 1;
            end
            for (int b = 0; b < tot; b++) dma_q.push_back(rnd_data());
            run_until_empty(500);
            chk($sformatf("vec%0d_beats", v), n_out, vecs[v].exp_beats);
            chk($sformatf("vec%0d_lasts", v), n_out_last, vecs[v].exp_lasts);
            chk($sformatf("vec%0d_done_cnt", v), done_cnt, cnt0 + DONE_CNT_W'(vecs[v].exp_lasts));
        end

        // maximum length: 64 beats, a 65th beat must wait for the next entry
        clr_counts();
        entry_q.push_back(63);
        for (int b = 0; b < 65; b++) dma_q.push_back(rnd_data());
        for (int i = 0; i < 75; i++) step();
        chk("max_held_beat", dma_q.size(), 1);
        chk("max_held_ready", trk.dma_rsp_ready, 1'b0);
        chk("max_beats", n_out, 64);
        chk("max_lasts", n_out_last, 1);
        entry_q.push_back(0);
        run_until_empty(50);
        chk("max_next_beats", n_out, 65);
        chk("max_next_lasts", n_out_last, 2);

        // clear coincident with a completion
        clr_counts();
        chk("clr_pre_nonzero", done_cnt != 0, 1'b1);
        entry_q.push_back(0);
        dma_q.push_back(rnd_data());
        n = 0;
        while (!m_active && n < 20) begin
            step();
            n++;
        end
        chk("clr_popped", m_active, 1'b1);
        done_cnt_clr = 1'b1;
        step();
        done_cnt_clr = 1'b0;
        chk("clr_done_cnt", done_cnt, '0);
        chk("clr_req_done", req_done, 1'b1);
        run_until_empty(50);

        // asynchronous reset in the middle of a 32-beat request
        clr_counts();
        entry_q.push_back(31);
        for (int b = 0; b < 32; b++) dma_q.push_back(rnd_data());
        n = 0;
        while (!(m_active && m_bcnt == 10) && n < 100) begin
            step();
            n++;
        end
        chk("midrst_reached", m_bcnt, 10);
        #2;
        reset_ = 1'b0;
        #1;
        chk("midrst_out_valid", trk.out_valid, 1'b0);
        chk("midrst_fifo_rdy", trk.fifo_rd_ready, 1'b1);
        chk("midrst_dma_rdy", trk.dma_rsp_ready, 1'b0);
        chk("midrst_done_cnt", done_cnt, '0);
        chk("midrst_idle", idle, 1'b1);
        entry_q.delete();
        dma_q.delete();
        sb.delete();
        m_active = 0; m_bcnt = 0; m_len = 0; m_cnt = '0; m_done_pend = 0;
        clr_counts();
        drive();
        @(negedge clk);
        reset_ = 1'b1;
        @(posedge clk);
        #1;
        entry_q.push_back(1);
        dma_q.push_back(rnd_data());
        dma_q.push_back(rnd_data());
        run_until_empty(50);
        chk("postrst_beats", n_out, 2);
        chk("postrst_lasts", n_out_last, 1);
        chk("postrst_done_cnt", done_cnt, 1);

        // completion counter wrap
        clr_counts();
        done_cnt_clr = 1'b1;
        step();
        done_cnt_clr = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            logic [DATA_W-1:0] d;
            d = {(DATA_W/32){i[31:0]}};
            entry_q.push_back(0);
            dma_q.push_back(d);
        end
        run_until_empty(70000);
        chk("wrap_full", done_cnt, 16'hFFFF);
        chk("wrap_beats", n_out, 65535);
        entry_q.push_back(0);
        dma_q.push_back(rnd_data());
        run_until_empty(50);
        chk("wrap_zero", done_cnt, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
